alu_share_arb: RTL and testbench

// - Shares one combinational aluR32I between NREQ requesters (e.g. execute stage, address-gen unit).
// - Round-robin arbitration, valid/ready handshakes, one registered result stage with backpressure.
// - Result returned to the granted requester only; fixed latency of 1 cycle when unstalled.

---
 rtl/alu_arb_pkg.sv | 13 +
 rtl/aluR32I.sv | 34 +++
 rtl/alucodesR32I.sv | 14 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/alu_share_arb.sv | 88 ++++++++
 tb/tb_alu_share_arb.sv | 271 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types for the ALU sharing arbiter: request bundle and output-stage states.
package alu_arb_pkg;
    localparam int unsigned NREQ_MAX = 8;
    localparam int unsigned ALU_W    = 32;

    typedef struct packed {
        logic [ALU_W-1:0] A;
        logic [ALU_W-1:0] B;
        logic [3:0]       alucode;
    } alu_req_t;

    typedef enum logic {EMPTY, FULL} stage_e;
endpackage

// File: rtl/aluR32I.sv
// Combinational RV32I-style ALU; undefined codes produce zero.
`ifndef ALUCODESR32I_SV
`include "alucodesR32I.sv"
`endif
module aluR32I #(
    parameter int unsigned dataW = 32
) (
    input  logic [3:0]       alucode,
    input  logic [dataW-1:0] op1,
    input  logic [dataW-1:0] op2,
    output logic [dataW-1:0] alu_result
);
    localparam int unsigned SW = $clog2(dataW);

    logic [SW-1:0] shamt;
    assign shamt = op2[SW-1:0];

    always_comb begin
        alu_result = '0;
        case (alucode)
            `ADD:    alu_result = op1 + op2;
            `SLT:    alu_result = {{(dataW-1){1'b0}}, $signed(op1) < $signed(op2)};
            `SLTU:   alu_result = {{(dataW-1){1'b0}}, op1 < op2};
            `AND:    alu_result = op1 & op2;
            `OR:     alu_result = op1 | op2;
            `XOR:    alu_result = op1 ^ op2;
            `SSL:    alu_result = op1 << shamt;
            `SSR:    alu_result = op1 >> shamt;
            `SRA:    alu_result = $unsigned($signed(op1) >>> shamt);
            `CPY:    alu_result = op2;
            default: alu_result = '0;
        endcase
    end
endmodule

// File: rtl/alucodesR32I.sv
// ALU operation codes shared by aluR32I and every block that drives it.
`ifndef ALUCODESR32I_SV
`define ALUCODESR32I_SV
`define ADD  4'd0
`define SLT  4'd1
`define SLTU 4'd2
`define AND  4'd3
`define OR   4'd4
`define XOR  4'd5
`define SSL  4'd6
`define SSR  4'd7
`define SRA  4'd8
`define CPY  4'd9
`endif

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
    parameter int unsigned N = 2,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);
    int unsigned j;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(ptr) + k) % N;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end
endmodule

// File: rtl/alu_share_arb.sv
// Shares one aluR32I among NREQ requesters with round-robin grant and a
// single registered result stage that supports backpressure.
module alu_share_arb
    import alu_arb_pkg::*;
#(
    parameter int unsigned dataW = 32,
    parameter int unsigned NREQ  = 2,
    localparam int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*dataW-1:0] req_A,
    input  logic [NREQ*dataW-1:0] req_B,
    input  logic [NREQ*4-1:0]     req_alucode,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [dataW-1:0]      rsp_result
);
    stage_e            stage_q, stage_d;
    logic [IW-1:0]     owner_q, ptr_q, gnt_idx;
    logic [NREQ-1:0]   grant;
    logic              gnt_any, stage_free, accept;
    logic [dataW-1:0]  alu_y, result_q;
    alu_req_t          sel;

    rr_arbiter #(.N(NREQ)) u_arb (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    always_comb begin
        sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel.A       = ALU_W'(req_A[i*dataW +: dataW]);
                sel.B       = ALU_W'(req_B[i*dataW +: dataW]);
                sel.alucode = req_alucode[i*4 +: 4];
            end
        end
    end

    aluR32I #(.dataW(dataW)) u_alu (
        .alucode    (sel.alucode),
        .op1        (dataW'(sel.A)),
        .op2        (dataW'(sel.B)),
        .alu_result (alu_y)
    );

    // Stage can take a new op if empty or its held result leaves this edge.
    assign stage_free = (stage_q == EMPTY) || rsp_ready[owner_q];
    assign accept     = gnt_any && stage_free && !reset;
    assign req_ready  = grant & {NREQ{stage_free && !reset}};
    assign rsp_result = result_q;

    always_comb begin
        stage_d   = stage_q;
        rsp_valid = '0;
        unique case (stage_q)
            EMPTY: if (accept) stage_d = FULL;
            FULL: begin
                rsp_valid[owner_q] = 1'b1;
                if (rsp_ready[owner_q]) stage_d = accept ? FULL : EMPTY;
            end
            default: stage_d = EMPTY;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stage_q  <= EMPTY;
            result_q <= '0;
            owner_q  <= '0;
            ptr_q    <= '0;
        end else begin
            stage_q <= stage_d;
            if (accept) begin
                result_q <= alu_y;
                owner_q  <= gnt_idx;
                ptr_q    <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_alu_share_arb.sv
// Scoreboard bench for alu_share_arb: directed ops, monitor checks every completed response.
`ifndef ALUCODESR32I_SV
`include "alucodesR32I.sv"
`endif
module tb_alu_share_arb;
    localparam int W = 32;
    localparam int N = 2;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_A = '0;
    logic [N*W-1:0] req_B = '0;
    logic [N*4-1:0] req_alucode = '0;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready = '0;
    logic [W-1:0]   rsp_result;

    typedef struct {
        int          owner;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    alu_share_arb #(.dataW(W), .NREQ(N)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_A       (req_A),
        .req_B       (req_B),
        .req_alucode (req_alucode),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result)
    );

    always #5 clock = ~clock;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(int i, bit v, logic [3:0] code, logic [31:0] a, logic [31:0] b);
        req_valid[i]           = v;
        req_A[i*W +: W]        = a;
        req_B[i*W +: W]        = b;
        req_alucode[i*4 +: 4]  = code;
    endtask

    task automatic expect_rsp(int o, logic [31:0] v);
        exp_t e;
        e.owner = o;
        e.val   = v;
        q.push_back(e);
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    // Monitor: a response completes when the owner's rsp_ready is high mid-cycle.
    always @(negedge clock) begin
        if (!reset && rsp_valid != '0) begin
            checks++;
            if ($countones(rsp_valid) != 1) begin
                errors++;
                $display("FAIL rsp_onehot: got %b expected one-hot", rsp_valid);
            end
            for (int i = 0; i < N; i++) begin
                if (rsp_valid[i] && rsp_ready[i]) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rsp_unexpected: got owner %0d result %h expected none",
                                 i, rsp_result);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk("rsp_owner", i, e.owner);
                        chk("rsp_result", rsp_result, e.val);
                    end
                end
            end
        end
    end

    logic [3:0]  c0 [3] = '{`ADD, `ADD, `AND};
    logic [31:0] a0 [3] = '{32'd1, 32'd10, 32'hFF};
    logic [31:0] b0 [3] = '{32'd2, 32'd20, 32'h0F};
    logic [31:0] e0 [3] = '{32'd3, 32'd30, 32'h0F};
    logic [3:0]  c1 [3] = '{`OR, `SSR, `CPY};
    logic [31:0] a1 [3] = '{32'hF0, 32'h8000_0000, 32'd0};
    logic [31:0] b1 [3] = '{32'h0F, 32'd4, 32'h55};
    logic [31:0] e1 [3] = '{32'hFF, 32'h0800_0000, 32'h55};

    initial begin
        int i0;
        int i1;
        int g;

        // Reset state, with requests pending to show req_ready stays low.
        tick;
        tick;
        drive(0, 1, `ADD, 32'd1, 32'd1);
        drive(1, 1, `ADD, 32'd2, 32'd2);
        settle;
        chk("reset_req_ready", 32'(req_ready), 32'b00);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'b00);
        chk("reset_rsp_result", rsp_result, 32'd0);
        drive(0, 0, `ADD, 0, 0);
        drive(1, 0, `ADD, 0, 0);
        reset = 1'b0;
        tick;

        // Single ADD, one-cycle latency.
        rsp_ready = 2'b11;
        drive(0, 1, `ADD, 32'd9, 32'd4);
        settle;
        chk("add_req_ready", 32'(req_ready), 32'b01);
        expect_rsp(0, 32'd13);
        tick;
        drive(0, 0, `ADD, 0, 0);
        settle;
        chk("add_rsp_valid", 32'(rsp_valid), 32'b01);
        chk("add_rsp_result", rsp_result, 32'd13);
        tick;

        // Simultaneous SLT / SLTU after reset: req0 wins first.
        reset = 1'b1;
        tick;
        reset = 1'b0;
        drive(0, 1, `SLT, 32'd2, 32'd4);
        drive(1, 1, `SLTU, 32'hFFFF_FFFF, 32'd4);
        settle;
        chk("slt_req_ready", 32'(req_ready), 32'b01);
        expect_rsp(0, 32'd1);
        tick;
        drive(0, 0, `ADD, 0, 0);
        settle;
        chk("sltu_req_ready", 32'(req_ready), 32'b10);
        expect_rsp(1, 32'd0);
        tick;
        drive(1, 0, `ADD, 0, 0);
        tick;

        // Backpressure: SRA result held while owner stalls; non-owner rsp_ready ignored.
        rsp_ready = 2'b00;
        drive(1, 1, `SRA, 32'hFFFF_FFF7, 32'd3);
        settle;
        chk("sra_req_ready", 32'(req_ready), 32'b10);
        expect_rsp(1, 32'hFFFF_FFFE);
        tick;
        drive(1, 0, `ADD, 0, 0);
        drive(0, 1, `ADD, 32'd1, 32'd1);
        for (int k = 0; k < 3; k++) begin
            rsp_ready = (k == 2) ? 2'b01 : 2'b00;
            settle;
            chk("stall_req_ready", 32'(req_ready), 32'b00);
            chk("stall_rsp_valid", 32'(rsp_valid), 32'b10);
            chk("stall_rsp_result", rsp_result, 32'hFFFF_FFFE);
            tick;
        end
        rsp_ready = 2'b10;
        settle;
        chk("release_req_ready", 32'(req_ready), 32'b01);
        expect_rsp(0, 32'd2);
        tick;
        drive(0, 0, `ADD, 0, 0);
        rsp_ready = 2'b11;
        tick;

        // Both requesters continuously valid: grants alternate 0,1,0,1,0,1.
        reset = 1'b1;
        tick;
        reset = 1'b0;
        i0 = 0;
        i1 = 0;
        for (int k = 0; k < 6; k++) begin
            drive(0, 1, c0[i0 % 3], a0[i0 % 3], b0[i0 % 3]);
            drive(1, 1, c1[i1 % 3], a1[i1 % 3], b1[i1 % 3]);
            g = k % 2;
            settle;
            chk("rr_req_ready", 32'(req_ready), 32'(1 << g));
            if (g == 0) begin
                expect_rsp(0, e0[i0 % 3]);
                i0++;
            end else begin
                expect_rsp(1, e1[i1 % 3]);
                i1++;
            end
            tick;
        end
        drive(0, 0, `ADD, 0, 0);
        drive(1, 0, `ADD, 0, 0);
        tick;

        // Reset while FULL discards the pending XOR result.
        rsp_ready = 2'b00;
        drive(0, 1, `XOR, 32'd9, 32'd4);
        settle;
        chk("xor_req_ready", 32'(req_ready), 32'b01);
        tick;
        drive(0, 0, `ADD, 0, 0);
        settle;
        chk("xor_rsp_valid", 32'(rsp_valid), 32'b01);
        chk("xor_rsp_result", rsp_result, 32'd13);
        tick;
        reset = 1'b1;
        drive(0, 1, `ADD, 32'd5, 32'd6);
        drive(1, 1, `OR, 32'd3, 32'd4);
        settle;
        chk("midrst_req_ready", 32'(req_ready), 32'b00);
        tick;
        reset = 1'b0;
        rsp_ready = 2'b11;
        settle;
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'b00);
        chk("midrst_rsp_result", rsp_result, 32'd0);
        chk("midrst_ptr_req_ready", 32'(req_ready), 32'b01);
        expect_rsp(0, 32'd11);
        tick;
        drive(0, 0, `ADD, 0, 0);
        settle;
        chk("midrst_req1_ready", 32'(req_ready), 32'b10);
        expect_rsp(1, 32'd7);
        tick;
        drive(1, 0, `ADD, 0, 0);
        tick;

        // SSL from req1 alone, then pointer must have wrapped to 0.
        drive(1, 1, `SSL, 32'd9, 32'd1);
        settle;
        chk("ssl_req_ready", 32'(req_ready), 32'b10);
        expect_rsp(1, 32'd18);
        tick;
        drive(0, 1, `SLTU, 32'd3, 32'd5);
        drive(1, 1, `CPY, 32'd0, 32'h55);
        settle;
        chk("wrap_req_ready", 32'(req_ready), 32'b01);
        expect_rsp(0, 32'd1);
        tick;
        drive(0, 0, `ADD, 0, 0);
        settle;
        chk("cpy_req_ready", 32'(req_ready), 32'b10);
        expect_rsp(1, 32'h55);
        tick;
        drive(1, 0, `ADD, 0, 0);

        // Bounded drain of outstanding responses.
        for (int k = 0; k < 20 && q.size() != 0; k++) tick;
        tick;
        chk("scoreboard_empty", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
